// File: rtl/csr_arb_pkg.sv
// Shared types, widths and helpers for the CSR access arbiter.
// Grant ids: 0 = pipeline, 1 = debug.
package csr_arb_pkg;

  localparam int DATA_W         = 24;
  localparam int IDX_W          = 12;
  localparam int TIMEOUT_DEF    = 15;
  localparam int STARVE_MAX_DEF = 4;
  localparam int TMR_W          = 8;
  localparam int STARVE_W       = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic GNT_P = 1'b0;
  localparam logic GNT_D = 1'b1;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v);
    if (v == {STARVE_W{1'b1}}) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/csr_arb_if.sv
// Requester ports plus the req/ack CSR bus seen by the arbiter.
// slave = arbiter view, master = environment (requesters + CSR file) view.
interface csr_arb_if;

  logic                             iw_p_req;
  logic                             iw_p_we;
  logic [csr_arb_pkg::IDX_W-1:0]    iw_p_idx;
  logic [csr_arb_pkg::DATA_W-1:0]   iw_p_wdata;
  logic                             iw_flush;
  logic [csr_arb_pkg::DATA_W-1:0]   ow_p_rdata;
  logic                             ow_p_done;
  logic                             ow_p_err;
  logic                             ow_stall;

  logic                             iw_d_req;
  logic                             iw_d_we;
  logic [csr_arb_pkg::IDX_W-1:0]    iw_d_idx;
  logic [csr_arb_pkg::DATA_W-1:0]   iw_d_wdata;
  logic [csr_arb_pkg::DATA_W-1:0]   ow_d_rdata;
  logic                             ow_d_done;
  logic                             ow_d_err;

  logic                             ow_csr_req;
  logic                             ow_csr_we;
  logic [csr_arb_pkg::IDX_W-1:0]    ow_csr_idx;
  logic [csr_arb_pkg::DATA_W-1:0]   ow_csr_wdata;
  logic                             iw_csr_ack;
  logic [csr_arb_pkg::DATA_W-1:0]   iw_csr_rdata;
  logic                             iw_csr_err;

  modport slave (
    input  iw_p_req, iw_p_we, iw_p_idx, iw_p_wdata, iw_flush,
    output ow_p_rdata, ow_p_done, ow_p_err, ow_stall,
    input  iw_d_req, iw_d_we, iw_d_idx, iw_d_wdata,
    output ow_d_rdata, ow_d_done, ow_d_err,
    output ow_csr_req, ow_csr_we, ow_csr_idx, ow_csr_wdata,
    input  iw_csr_ack, iw_csr_rdata, iw_csr_err
  );

  modport master (
    output iw_p_req, iw_p_we, iw_p_idx, iw_p_wdata, iw_flush,
    input  ow_p_rdata, ow_p_done, ow_p_err, ow_stall,
    output iw_d_req, iw_d_we, iw_d_idx, iw_d_wdata,
    input  ow_d_rdata, ow_d_done, ow_d_err,
    input  ow_csr_req, ow_csr_we, ow_csr_idx, ow_csr_wdata,
    output iw_csr_ack, iw_csr_rdata, iw_csr_err
  );

endinterface

// File: rtl/csr_arb_pick.sv
// Combinational pick between pipeline and debug requests.
// Pipeline has priority unless debug has been starved STARVE_MAX times.
module csr_arb_pick
  import csr_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                p_req,
  input  logic                d_req,
  input  logic                flush,
  input  logic [STARVE_W-1:0] starve_cnt,
  output logic                gnt_vld,
  output logic                gnt_id
);

  logic p_ok_s;

  // Priority pick; a flushed pipeline request is never eligible.
  always_comb begin
    p_ok_s  = p_req & ~flush;
    gnt_vld = 1'b0;
    gnt_id  = GNT_P;
    if (p_ok_s && d_req) begin
      gnt_vld = 1'b1;
      gnt_id  = (starve_cnt >= STARVE_W'(STARVE_MAX)) ? GNT_D : GNT_P;
    end else if (p_ok_s) begin
      gnt_vld = 1'b1;
      gnt_id  = GNT_P;
    end else if (d_req) begin
      gnt_vld = 1'b1;
      gnt_id  = GNT_D;
    end else begin
      gnt_vld = 1'b0;
      gnt_id  = GNT_P;
    end
  end

endmodule

// File: rtl/csr_arb.sv
// Two-requester CSR bus arbiter: pick, issue with timeout, return response.
// Stall is the only combinational output.
module csr_arb
  import csr_arb_pkg::*;
#(
  parameter int TIMEOUT    = TIMEOUT_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic      iw_clk,
  input logic      iw_rst,
  csr_arb_if.slave bus
);

  state_e                state_r;
  logic                  gnt_id_r;
  logic                  flushed_r;
  logic [TMR_W-1:0]      timer_r;
  logic [STARVE_W-1:0]   starve_r;

  logic                  gnt_vld_s;
  logic                  gnt_id_s;
  logic                  contested_s;
  logic                  timeout_s;
  logic                  p_flush_s;
  logic [DATA_W-1:0]     resp_rdata_s;
  logic                  resp_err_s;

  csr_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .p_req      (bus.iw_p_req),
    .d_req      (bus.iw_d_req),
    .flush      (bus.iw_flush),
    .starve_cnt (starve_r),
    .gnt_vld    (gnt_vld_s),
    .gnt_id     (gnt_id_s)
  );

  // Response selection: ack beats timeout, writes return zero data.
  always_comb begin
    contested_s = bus.iw_p_req & ~bus.iw_flush & bus.iw_d_req;
    timeout_s   = (timer_r == TMR_W'(TIMEOUT - 1));
    p_flush_s   = flushed_r | bus.iw_flush;
    if (bus.iw_csr_ack) begin
      resp_rdata_s = bus.ow_csr_we ? {DATA_W{1'b0}} : bus.iw_csr_rdata;
      resp_err_s   = bus.iw_csr_err;
    end else begin
      resp_rdata_s = {DATA_W{1'b0}};
      resp_err_s   = 1'b1;
    end
  end

  assign bus.ow_stall = bus.iw_p_req & ~bus.iw_flush &
                        ~((state_r == ST_RESP) & (gnt_id_r == GNT_P) & ~flushed_r);

  // Arbiter FSM with registered bus and response outputs.
  always_ff @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      state_r          <= ST_IDLE;
      gnt_id_r         <= GNT_P;
      flushed_r        <= 1'b0;
      timer_r          <= {TMR_W{1'b0}};
      starve_r         <= {STARVE_W{1'b0}};
      bus.ow_csr_req   <= 1'b0;
      bus.ow_csr_we    <= 1'b0;
      bus.ow_csr_idx   <= {IDX_W{1'b0}};
      bus.ow_csr_wdata <= {DATA_W{1'b0}};
      bus.ow_p_done    <= 1'b0;
      bus.ow_p_rdata   <= {DATA_W{1'b0}};
      bus.ow_p_err     <= 1'b0;
      bus.ow_d_done    <= 1'b0;
      bus.ow_d_rdata   <= {DATA_W{1'b0}};
      bus.ow_d_err     <= 1'b0;
    end else begin
      bus.ow_p_done <= 1'b0;
      bus.ow_d_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (gnt_vld_s) begin
            state_r        <= ST_ISSUE;
            gnt_id_r       <= gnt_id_s;
            timer_r        <= {TMR_W{1'b0}};
            bus.ow_csr_req <= 1'b1;
            if (gnt_id_s == GNT_D) begin
              bus.ow_csr_we    <= bus.iw_d_we;
              bus.ow_csr_idx   <= bus.iw_d_idx;
              bus.ow_csr_wdata <= bus.iw_d_wdata;
              starve_r         <= {STARVE_W{1'b0}};
            end else begin
              bus.ow_csr_we    <= bus.iw_p_we;
              bus.ow_csr_idx   <= bus.iw_p_idx;
              bus.ow_csr_wdata <= bus.iw_p_wdata;
              starve_r         <= contested_s ? sat_inc(starve_r) : starve_r;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if ((gnt_id_r == GNT_P) && bus.iw_flush) begin
            flushed_r <= 1'b1;
          end
          if (bus.iw_csr_ack || timeout_s) begin
            state_r        <= ST_RESP;
            bus.ow_csr_req <= 1'b0;
            if (gnt_id_r == GNT_D) begin
              bus.ow_d_done  <= 1'b1;
              bus.ow_d_rdata <= resp_rdata_s;
              bus.ow_d_err   <= resp_err_s;
            end else if (!p_flush_s) begin
              bus.ow_p_done  <= 1'b1;
              bus.ow_p_rdata <= resp_rdata_s;
              bus.ow_p_err   <= resp_err_s;
            end else begin
              bus.ow_p_done <= 1'b0;
            end
          end else begin
            timer_r <= timer_r + 8'd1;
          end
        end
        ST_RESP: begin
          state_r   <= ST_IDLE;
          flushed_r <= 1'b0;
        end
        default: begin
          state_r        <= ST_IDLE;
          bus.ow_csr_req <= 1'b0;
          flushed_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_arb.sv
// Directed bench for csr_arb: transaction-level reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_csr_arb;
  import csr_arb_pkg::*;

  logic iw_clk = 1'b0;
  logic iw_rst = 1'b0;
  always #5 iw_clk = ~iw_clk;

  csr_arb_if bus ();

  csr_arb #(.TIMEOUT(15), .STARVE_MAX(4)) dut (
    .iw_clk (iw_clk),
    .iw_rst (iw_rst),
    .bus    (bus)
  );

  // Bench-driven inputs
  logic        p_req = 1'b0, p_we = 1'b0, flush = 1'b0;
  logic [11:0] p_idx = 12'h000;
  logic [23:0] p_wdata = 24'h000000;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [11:0] d_idx = 12'h000;
  logic [23:0] d_wdata = 24'h000000;
  logic        ack = 1'b0, rsp_err = 1'b0, ack_err = 1'b0;
  logic [23:0] rsp_rdata = 24'h000000, ack_rdata = 24'h000000;

  assign bus.iw_p_req     = p_req;
  assign bus.iw_p_we      = p_we;
  assign bus.iw_p_idx     = p_idx;
  assign bus.iw_p_wdata   = p_wdata;
  assign bus.iw_flush     = flush;
  assign bus.iw_d_req     = d_req;
  assign bus.iw_d_we      = d_we;
  assign bus.iw_d_idx     = d_idx;
  assign bus.iw_d_wdata   = d_wdata;
  assign bus.iw_csr_ack   = ack;
  assign bus.iw_csr_rdata = ack_rdata;
  assign bus.iw_csr_err   = ack_err;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CSR file responder: ack after ack_delay cycles of csr_req (-1 = never)
  int ack_delay = -1;
  int rsp_cnt   = 0;
  always @(negedge iw_clk) begin
    if (bus.ow_csr_req) begin
      ack       = (rsp_cnt == ack_delay);
      ack_rdata = rsp_rdata;
      ack_err   = rsp_err;
      rsp_cnt++;
    end else begin
      ack     = 1'b0;
      rsp_cnt = 0;
    end
  end

  int wr_acks = 0;
  always @(posedge iw_clk) begin
    if (bus.ow_csr_req && ack && bus.ow_csr_we) wr_acks++;
  end

  // Reference model: one transaction at a time, owner 0=P 1=D
  bit          m_on_bus, m_finish, m_owner, m_flushed, m_p_ok, m_win_d;
  int          m_age, m_starve;
  logic        exp_csr_req, exp_we, exp_p_done, exp_d_done, exp_p_err, exp_d_err, r_err;
  logic [11:0] exp_idx;
  logic [23:0] exp_wdata, exp_p_rdata, exp_d_rdata, r_data;

  always @(posedge iw_clk or negedge iw_rst) begin
    if (!iw_rst) begin
      m_on_bus = 0; m_finish = 0; m_owner = 0; m_flushed = 0; m_age = 0; m_starve = 0;
      exp_csr_req = 0; exp_we = 0; exp_idx = 12'h000; exp_wdata = 24'h000000;
      exp_p_done = 0; exp_d_done = 0; exp_p_err = 0; exp_d_err = 0;
      exp_p_rdata = 24'h000000; exp_d_rdata = 24'h000000;
    end else begin
      exp_p_done = 0;
      exp_d_done = 0;
      if (m_finish) begin
        m_finish  = 0;
        m_flushed = 0;
      end else if (m_on_bus) begin
        if (!m_owner && flush) m_flushed = 1;
        if (ack || m_age == 14) begin
          r_data = ack ? (exp_we ? 24'h000000 : ack_rdata) : 24'h000000;
          r_err  = ack ? ack_err : 1'b1;
          m_on_bus = 0; m_finish = 1; exp_csr_req = 0;
          if (m_owner) begin
            exp_d_done = 1; exp_d_rdata = r_data; exp_d_err = r_err;
          end else if (!m_flushed) begin
            exp_p_done = 1; exp_p_rdata = r_data; exp_p_err = r_err;
          end
        end else begin
          m_age++;
        end
      end else begin
        m_p_ok = p_req && !flush;
        if (m_p_ok || d_req) begin
          m_win_d = !m_p_ok || (d_req && m_starve >= 4);
          if (m_win_d) m_starve = 0;
          else if (d_req) m_starve++;
          m_owner = m_win_d; m_on_bus = 1; m_age = 0; exp_csr_req = 1;
          exp_we    = m_win_d ? d_we : p_we;
          exp_idx   = m_win_d ? d_idx : p_idx;
          exp_wdata = m_win_d ? d_wdata : p_wdata;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge iw_clk) begin
    #2;
    chk("cmp_csr_req", bus.ow_csr_req, exp_csr_req);
    if (exp_csr_req) begin
      chk("cmp_csr_we", bus.ow_csr_we, exp_we);
      chk("cmp_csr_idx", bus.ow_csr_idx, exp_idx);
      chk("cmp_csr_wdata", bus.ow_csr_wdata, exp_wdata);
    end
    chk("cmp_p_done", bus.ow_p_done, exp_p_done);
    chk("cmp_d_done", bus.ow_d_done, exp_d_done);
    chk("cmp_p_rdata", bus.ow_p_rdata, exp_p_rdata);
    chk("cmp_p_err", bus.ow_p_err, exp_p_err);
    chk("cmp_d_rdata", bus.ow_d_rdata, exp_d_rdata);
    chk("cmp_d_err", bus.ow_d_err, exp_d_err);
    chk("cmp_stall", bus.ow_stall, p_req & ~flush & ~(m_finish & ~m_owner & ~m_flushed));
  end

  task automatic wait_done(input bit dbg, input int budget, output int n, output bit got);
    got = 0;
    n   = 0;
    while (!got && n < budget) begin
      @(negedge iw_clk);
      n++;
      got = dbg ? bus.ow_d_done : bus.ow_p_done;
    end
  endtask

  int    n, cnt, wr0;
  bit    got, pdone_seen;
  string seq;

  initial begin
    // Reset state
    repeat (2) @(negedge iw_clk);
    chk("rst_csr_req", bus.ow_csr_req, 1'b0);
    chk("rst_p_done", bus.ow_p_done, 1'b0);
    chk("rst_d_done", bus.ow_d_done, 1'b0);
    chk("rst_stall", bus.ow_stall, 1'b0);
    iw_rst = 1'b1;

    // Pipeline read, ack two cycles after csr_req rises
    @(negedge iw_clk);
    ack_delay = 2; rsp_rdata = 24'h00A5B6; rsp_err = 1'b0;
    p_req = 1'b1; p_we = 1'b0; p_idx = 12'h001; p_wdata = 24'h000000;
    n = 0; got = 0;
    while (!got && n < 20) begin
      @(negedge iw_clk);
      n++;
      got = bus.ow_p_done;
      if (!got) chk("prd_stall_busy", bus.ow_stall, 1'b1);
    end
    chk("prd_done_seen", got, 1'b1);
    chk("prd_latency", n, 4);
    chk("prd_stall_done", bus.ow_stall, 1'b0);
    chk("prd_rdata", bus.ow_p_rdata, 24'h00A5B6);
    chk("prd_err", bus.ow_p_err, 1'b0);
    p_req = 1'b0;

    // Debug write, immediate ack
    @(negedge iw_clk);
    ack_delay = 0;
    d_req = 1'b1; d_we = 1'b1; d_idx = 12'h010; d_wdata = 24'h00EF12;
    @(negedge iw_clk);
    chk("dwr_csr_req", bus.ow_csr_req, 1'b1);
    chk("dwr_csr_we", bus.ow_csr_we, 1'b1);
    chk("dwr_csr_wdata", bus.ow_csr_wdata, 24'h00EF12);
    chk("dwr_csr_idx", bus.ow_csr_idx, 12'h010);
    @(negedge iw_clk);
    chk("dwr_d_done", bus.ow_d_done, 1'b1);
    chk("dwr_p_done", bus.ow_p_done, 1'b0);
    chk("dwr_d_err", bus.ow_d_err, 1'b0);
    d_req = 1'b0;

    // Contention with starvation relief
    @(negedge iw_clk);
    ack_delay = 0; rsp_rdata = 24'h000111;
    p_req = 1'b1; p_we = 1'b0; p_idx = 12'h002;
    d_req = 1'b1; d_we = 1'b0; d_idx = 12'h003;
    seq = ""; n = 0;
    while (seq.len() < 10 && n < 60) begin
      @(negedge iw_clk);
      n++;
      if (bus.ow_p_done) seq = {seq, "P"};
      if (bus.ow_d_done) seq = {seq, "D"};
    end
    p_req = 1'b0; d_req = 1'b0;
    checks++;
    if (seq != "PPPPDPPPPD") begin
      errors++;
      $display("FAIL contention_seq: got %s expected PPPPDPPPPD", seq);
    end

    // Timeout on a pipeline read
    @(negedge iw_clk);
    ack_delay = -1;
    p_req = 1'b1; p_we = 1'b0; p_idx = 12'h7FF;
    n = 0; cnt = 0; got = 0;
    while (!got && n < 40) begin
      @(negedge iw_clk);
      n++;
      if (bus.ow_csr_req) cnt++;
      got = bus.ow_p_done;
    end
    chk("tmo_done_seen", got, 1'b1);
    chk("tmo_req_cycles", cnt, 15);
    chk("tmo_latency", n, 16);
    chk("tmo_err", bus.ow_p_err, 1'b1);
    chk("tmo_rdata", bus.ow_p_rdata, 24'h000000);
    p_req = 1'b0;
    @(negedge iw_clk);
    chk("tmo_idle_req", bus.ow_csr_req, 1'b0);

    // Flush during a pipeline write, debug waiting behind it
    @(negedge iw_clk);
    ack_delay = 3; rsp_rdata = 24'hABCDEF; wr0 = wr_acks;
    p_req = 1'b1; p_we = 1'b1; p_idx = 12'h005; p_wdata = 24'h00BEEF;
    @(negedge iw_clk);
    flush = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_idx = 12'h006;
    @(negedge iw_clk);
    flush = 1'b0; p_req = 1'b0;
    n = 0; got = 0; pdone_seen = 0;
    while (!got && n < 30) begin
      @(negedge iw_clk);
      n++;
      if (bus.ow_p_done) pdone_seen = 1;
      got = bus.ow_d_done;
    end
    d_req = 1'b0;
    chk("fl_p_done_never", pdone_seen, 1'b0);
    chk("fl_write_acked", wr_acks - wr0, 1);
    chk("fl_d_done_seen", got, 1'b1);
    chk("fl_d_rdata", bus.ow_d_rdata, 24'hABCDEF);

    // Pipeline write returning a bus error
    @(negedge iw_clk);
    ack_delay = 1; rsp_rdata = 24'h555555; rsp_err = 1'b1;
    p_req = 1'b1; p_we = 1'b1; p_idx = 12'hC00; p_wdata = 24'h000042;
    wait_done(1'b0, 20, n, got);
    p_req = 1'b0;
    chk("perr_done_seen", got, 1'b1);
    chk("perr_latency", n, 3);
    chk("perr_err", bus.ow_p_err, 1'b1);
    chk("perr_rdata", bus.ow_p_rdata, 24'h000000);
    rsp_err = 1'b0;

    // Asynchronous reset mid-ISSUE
    @(negedge iw_clk);
    ack_delay = -1;
    p_req = 1'b1; p_we = 1'b0; p_idx = 12'h008;
    repeat (3) @(negedge iw_clk);
    chk("arst_req_before", bus.ow_csr_req, 1'b1);
    #3 iw_rst = 1'b0;
    #1 chk("arst_req_drop", bus.ow_csr_req, 1'b0);
    p_req = 1'b0;
    @(negedge iw_clk);
    iw_rst = 1'b1;
    @(negedge iw_clk);
    ack_delay = 1; rsp_rdata = 24'h123456;
    d_req = 1'b1; d_we = 1'b0; d_idx = 12'h020;
    wait_done(1'b1, 20, n, got);
    d_req = 1'b0;
    chk("arst_d_done_seen", got, 1'b1);
    chk("arst_d_latency", n, 3);
    chk("arst_d_rdata", bus.ow_d_rdata, 24'h123456);
    chk("arst_d_err", bus.ow_d_err, 1'b0);

    repeat (3) @(negedge iw_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_arb.md
Name: csr_arb

Overview:
- Arbitrates the single CSR access bus between two requesters: the pipeline (CSRRD/CSRWR issued from the EX stage) and the debug/host port.
- Captures the winning request and drives a req/ack CSR bus with variable latency and a timeout.
- Returns read data, done and error to the winner, and stalls the pipeline while its access is outstanding.
- Sits between stg_ex and the CSR file / debug module.

Parameters:
- DATA_W, 24, CSR data width (matches core data width).
- IDX_W, 12, CSR index width.
- TIMEOUT, 15, max cycles in ISSUE waiting for ack before error completion (1..255).
- STARVE_MAX, 4, consecutive debug losses after which debug wins the next contested arbitration.

Ports:
- iw_clk  in  1  clock.
- iw_rst  in  1  asynchronous active-low reset (asserted = 0).
- iw_p_req  in  1  pipeline request, level; held until ow_p_done or flush.
- iw_p_we  in  1  pipeline write (CSRWR) = 1, read (CSRRD) = 0.
- iw_p_idx  in  IDX_W  pipeline CSR index.
- iw_p_wdata  in  DATA_W  pipeline write data.
- iw_flush  in  1  pipeline flush.
- ow_p_rdata  out  DATA_W  pipeline read data, valid with ow_p_done.
- ow_p_done  out  1  pipeline completion pulse.
- ow_p_err  out  1  pipeline error, valid with ow_p_done.
- ow_stall  out  1  pipeline stall.
- iw_d_req, iw_d_we, iw_d_idx, iw_d_wdata  in  1/1/IDX_W/DATA_W  debug port, same rules as pipeline.
- ow_d_rdata, ow_d_done, ow_d_err  out  DATA_W/1/1  debug response.
- ow_csr_req  out  1  CSR bus request.
- ow_csr_we  out  1  CSR bus write enable.
- ow_csr_idx  out  IDX_W  CSR bus index.
- ow_csr_wdata  out  DATA_W  CSR bus write data.
- iw_csr_ack  in  1  CSR bus completion, one cycle.
- iw_csr_rdata  in  DATA_W  CSR bus read data, valid with ack.
- iw_csr_err  in  1  CSR bus error (bad index / write to read-only), valid with ack.

Behaviour:
- Reset (async, iw_rst=0): state IDLE; all outputs 0; starve counter 0; timer 0; flushed flag 0. Reset mid-transaction drops ow_csr_req immediately; the transaction is abandoned.
- FSM states: IDLE, ISSUE, RESP. All outputs are registered except ow_stall.
- IDLE:
  - No request: stay in IDLE.
  - Only one requester: grant it.
  - Both request: pipeline wins unless starve counter >= STARVE_MAX, in which case debug wins.
  - Starve counter: +1 (saturating) when debug loses a contested arbitration; cleared when debug is granted.
  - Pipeline request with iw_flush=1 in the same cycle is not granted.
  - On grant: latch we/idx/wdata and grant id into ow_csr_*; go to ISSUE; timer = 0.
- ISSUE:
  - ow_csr_req = 1; ow_csr_* stay stable.
  - iw_csr_ack=1: latch rdata (reads; writes latch 0) and err; go to RESP.
  - No ack: timer +1. When timer reaches TIMEOUT-1 without ack, go to RESP with rdata = 0, err = 1.
  - ack in the same cycle as timeout: ack wins.
- RESP: ow_csr_req = 0. The granted port's done pulse is high this cycle with its rdata/err; the other port's outputs stay 0. Then go to IDLE.
- Latency: req sampled in cycle N; ow_csr_req high from N+1; ack at cycle M gives done at M+1. Minimum: ack at N+1, done at N+2.
- Handshake: the requester keeps req and payload stable until done. It must deassert req on the edge ending the done cycle. A req still high in the cycle after done is a new request (back-to-back allowed).
- rdata/err hold their value after done until the next done for that port.
- Flush:
  - iw_flush while the pipeline is granted (ISSUE/RESP) sets the flushed flag.
  - The bus transaction still completes, including writes; ow_p_done is suppressed for it.
  - The flag clears on return to IDLE. The pipeline drops iw_p_req on flush.
- ow_stall = iw_p_req & ~iw_flush & ~(state==RESP & grant==pipeline & ~flushed). Combinational.
- Grant ids: 0 = pipeline, 1 = debug.

Decomposition:
- csr_arb.vh: state encodings (IDLE/ISSUE/RESP), grant ids, default widths; included alongside sizes.vh.
- One sub-module, csr_arb_pick: combinational priority + starvation pick. Inputs: both reqs, flush, starve count. Outputs: grant valid, grant id. The starve counter stays in csr_arb.
- The timer stays inline.

Test Plan:
- Pipeline read: p_req, we=0, idx=0x001; ack 2 cycles after ow_csr_req with rdata=0x00A5B6 -> ow_p_done pulse with rdata 0x00A5B6, err=0; ow_stall high until done cycle, low in done cycle.
- Debug write: idx=0x010, wdata=0x00EF12; ack immediately -> ow_csr_we=1, ow_csr_wdata=0x00EF12 stable during ISSUE; ow_d_done at N+2; ow_p_done stays 0.
- Contention: both ports request continuously with immediate acks -> grant sequence P,P,P,P,D,P,P,P,P,D (STARVE_MAX=4).
- Timeout: pipeline read with no ack -> ow_csr_req high exactly 15 cycles; ow_p_done with err=1, rdata=0x000000; state returns to IDLE.
- Flush: pipeline write granted, iw_flush pulse during ISSUE, ack after 3 cycles -> bus write completes; ow_p_done never pulses; a pending debug req is granted next.
- Async reset: assert iw_rst=0 mid-ISSUE -> ow_csr_req falls without a clock edge; after release, a fresh debug read completes normally.
